// File: rtl/spm_pkg.sv
// rtl/spm_pkg.sv - shared encodings for the RISC-SPM memory arbiter and processor opcodes
package spm_pkg;

  // Arbiter state: who owns the single memory port this cycle
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CPU  = 2'd1,
    S_DBG  = 2'd2
  } arb_state_e;

  // Most recent owner, used to break ties fairly
  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DBG = 1'b1
  } owner_e;

  // RISC-SPM instruction opcodes (upper nibble of the instruction word)
  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_RD  = 4'd5;
  localparam logic [3:0] OP_WR  = 4'd6;
  localparam logic [3:0] OP_BR  = 4'd7;
  localparam logic [3:0] OP_BRZ = 4'd8;

  // Width needed to hold max_val-1; a one-cycle burst still needs a 1-bit counter
  function automatic int unsigned sat_cnt_width(input int unsigned max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/spm_sat_cnt.sv
// rtl/spm_sat_cnt.sv - saturating up-counter with synchronous clear
module spm_sat_cnt #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned MAX   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Clear wins over increment; increment stops at MAX
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q < MAX_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register, cleared asynchronously on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/spm_mem_arbiter.sv
// rtl/spm_mem_arbiter.sv - round-robin, burst-limited arbiter sharing SPM memory between CPU and debug
module spm_mem_arbiter
  import spm_pkg::*;
#(
  parameter int unsigned WORD_SZ   = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [WORD_SZ-1:0] cpu_addr,
  input  logic [WORD_SZ-1:0] cpu_wdata,
  output logic               cpu_gnt,
  output logic [WORD_SZ-1:0] cpu_rdata,
  input  logic               dbg_req,
  input  logic               dbg_we,
  input  logic [WORD_SZ-1:0] dbg_addr,
  input  logic [WORD_SZ-1:0] dbg_wdata,
  output logic               dbg_gnt,
  output logic [WORD_SZ-1:0] dbg_rdata,
  input  logic               dbg_halt,
  output logic [WORD_SZ-1:0] mem_addr,
  output logic [WORD_SZ-1:0] mem_wdata,
  output logic               mem_write,
  input  logic [WORD_SZ-1:0] mem_rdata
);

  localparam int unsigned      CNT_W      = sat_cnt_width(MAX_BURST);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_e       state_q;
  arb_state_e       state_d;
  owner_e           last_owner_q;
  logic [CNT_W-1:0] burst_cnt;
  logic             cpu_ok;
  logic             dbg_ok;
  logic             burst_open;
  logic             burst_clr;
  logic             burst_inc;

  // Halt masks the CPU completely; debug is always eligible when requesting
  assign cpu_ok     = cpu_req & ~dbg_halt;
  assign dbg_ok     = dbg_req;
  assign burst_open = (burst_cnt < BURST_LAST);

  // Next owner: the current owner keeps the port until its burst is spent and the other side waits
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_ok && dbg_ok) begin
          state_d = (last_owner_q == OWNER_DBG) ? S_CPU : S_DBG;
        end else if (cpu_ok) begin
          state_d = S_CPU;
        end else if (dbg_ok) begin
          state_d = S_DBG;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CPU: begin
        if (cpu_ok && (!dbg_ok || burst_open)) begin
          state_d = S_CPU;
        end else if (dbg_ok) begin
          state_d = S_DBG;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DBG: begin
        if (dbg_ok && (!cpu_ok || burst_open)) begin
          state_d = S_DBG;
        end else if (cpu_ok) begin
          state_d = S_CPU;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Arbiter state and round-robin memory; reset hands the first tie to the CPU
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      last_owner_q <= OWNER_DBG;
    end else begin
      state_q <= state_d;
      if (state_d == S_CPU) begin
        last_owner_q <= OWNER_CPU;
      end else if (state_d == S_DBG) begin
        last_owner_q <= OWNER_DBG;
      end
    end
  end

  // Burst length of the current owner restarts whenever ownership changes
  assign burst_clr = (state_d != state_q);
  assign burst_inc = (state_q != S_IDLE);

  spm_sat_cnt #(
    .WIDTH (CNT_W),
    .MAX   (MAX_BURST - 1)
  ) u_burst_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (burst_clr),
    .inc_i (burst_inc),
    .cnt_o (burst_cnt)
  );

  assign cpu_gnt = (state_q == S_CPU);
  assign dbg_gnt = (state_q == S_DBG);

  // Memory port follows the owner; a dropped request suppresses the write in the same cycle
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    cpu_rdata = '0;
    dbg_rdata = '0;
    case (state_q)
      S_CPU: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_write = cpu_we & cpu_req;
        cpu_rdata = mem_rdata;
      end
      S_DBG: begin
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
        mem_write = dbg_we & dbg_req;
        dbg_rdata = mem_rdata;
      end
      default: begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_write = 1'b0;
      end
    endcase
  end

  ap_write_single_owner : assert property (
    @(posedge clk) disable iff (!rst) mem_write |-> (cpu_gnt ^ dbg_gnt)
  );

endmodule

// File: tb/tb_spm_mem_arbiter.sv
// tb/tb_spm_mem_arbiter.sv - scoreboard bench for spm_mem_arbiter with a behavioural ownership model
module tb_spm_mem_arbiter;

  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0, dbg_halt = 1'b0;
  logic [7:0] cpu_addr = '0, cpu_wdata = '0, dbg_addr = '0, dbg_wdata = '0;
  logic       cpu_gnt, dbg_gnt, mem_write;
  logic [7:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];

  typedef struct {
    string      tag;
    logic       cg;
    logic       dg;
    logic       mw;
    logic [7:0] ma;
    logic [7:0] md;
    logic [7:0] cr;
    logic [7:0] dr;
  } exp_t;

  exp_t sb_q[$];
  event chk_ev;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Ownership model: 0 = nobody, 1 = CPU, 2 = debug; run = cycles held so far
  int m_owner = 0;
  int m_run   = 0;
  int m_last  = 2;

  always #5 clk = ~clk;

  spm_mem_arbiter #(.WORD_SZ(8), .MAX_BURST(MB)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_rdata (cpu_rdata),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_gnt   (dbg_gnt),
    .dbg_rdata (dbg_rdata),
    .dbg_halt  (dbg_halt),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 7 + 60);
  endfunction

  // mem_unit stand-in: combinational read, write on rising edge
  assign mem_rdata = mem[mem_addr];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (mem_write) mem[mem_addr] = mem_wdata;
    end
  end

  task automatic model_reset();
    m_owner = 0;
    m_run   = 0;
    m_last  = 2;
  endtask

  // Expected port view for the current owner and the inputs now applied
  task automatic push_expect(input string tag);
    exp_t e;
    e.tag = tag;
    e.cg  = (m_owner == 1);
    e.dg  = (m_owner == 2);
    e.mw  = 1'b0;
    e.ma  = 8'h00;
    e.md  = 8'h00;
    e.cr  = 8'h00;
    e.dr  = 8'h00;
    if (m_owner == 1) begin
      e.ma = cpu_addr;
      e.md = cpu_wdata;
      e.mw = cpu_req && cpu_we;
      e.cr = ref_mem[cpu_addr];
    end else if (m_owner == 2) begin
      e.ma = dbg_addr;
      e.md = dbg_wdata;
      e.mw = dbg_req && dbg_we;
      e.dr = ref_mem[dbg_addr];
    end
    sb_q.push_back(e);
    ->chk_ev;
    #2;
  endtask

  task automatic drive(input string tag, input bit r,
                       input bit creq, input bit cwe, input logic [7:0] ca, input logic [7:0] cwd,
                       input bit dreq, input bit dwe, input logic [7:0] da, input logic [7:0] dwd,
                       input bit halt);
    @(negedge clk);
    rst       = r;
    cpu_req   = creq;
    cpu_we    = cwe;
    cpu_addr  = ca;
    cpu_wdata = cwd;
    dbg_req   = dreq;
    dbg_we    = dwe;
    dbg_addr  = da;
    dbg_wdata = dwd;
    dbg_halt  = halt;
    if (!r) model_reset();
    push_expect(tag);
  endtask

  // Ownership rules at the coming edge, stated in terms of run length
  task automatic advance();
    int nxt;
    bit c_ok, d_ok;
    if (!rst) begin
      model_reset();
      return;
    end
    if (m_owner == 1 && cpu_req && cpu_we) ref_mem[cpu_addr] = cpu_wdata;
    if (m_owner == 2 && dbg_req && dbg_we) ref_mem[dbg_addr] = dbg_wdata;
    c_ok = cpu_req && !dbg_halt;
    d_ok = dbg_req;
    if (m_owner == 1 && c_ok && !(d_ok && m_run >= MB)) nxt = 1;
    else if (m_owner == 2 && d_ok && !(c_ok && m_run >= MB)) nxt = 2;
    else if (c_ok && d_ok) nxt = (m_owner != 0) ? 3 - m_owner : 3 - m_last;
    else if (c_ok) nxt = 1;
    else if (d_ok) nxt = 2;
    else nxt = 0;
    m_run = (nxt != 0 && nxt == m_owner) ? m_run + 1 : ((nxt != 0) ? 1 : 0);
    if (nxt != 0) m_last = nxt;
    m_owner = nxt;
  endtask

  task automatic cyc(input string tag, input bit r,
                     input bit creq, input bit cwe, input logic [7:0] ca, input logic [7:0] cwd,
                     input bit dreq, input bit dwe, input logic [7:0] da, input logic [7:0] dwd,
                     input bit halt);
    drive(tag, r, creq, cwe, ca, cwd, dreq, dwe, da, dwd, halt);
    advance();
  endtask

  task automatic check8(input string tag, input logic [7:0] act, input logic [7:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", tag, act, req);
    end
  endtask

  // Monitor: compares every presented cycle against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      #1;
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow: got DUT cycle, expected a queued entry");
      end else begin
        e = sb_q.pop_front();
        if (cpu_gnt !== e.cg || dbg_gnt !== e.dg || mem_write !== e.mw || mem_addr !== e.ma ||
            mem_wdata !== e.md || cpu_rdata !== e.cr || dbg_rdata !== e.dr) begin
          n_fail++;
          $display("FAIL %s: got cg=%0b dg=%0b mw=%0b ma=%02h md=%02h cr=%02h dr=%02h, expected cg=%0b dg=%0b mw=%0b ma=%02h md=%02h cr=%02h dr=%02h",
                   e.tag, cpu_gnt, dbg_gnt, mem_write, mem_addr, mem_wdata, cpu_rdata, dbg_rdata,
                   e.cg, e.dg, e.mw, e.ma, e.md, e.cr, e.dr);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

    // Reset held with both requesters active
    repeat (3) cyc("reset_hold", 1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0);

    // Constant contention: CPU x4, DBG x4, CPU x4 with no idle gap
    for (int i = 0; i < 14; i++)
      cyc("contend", 1'b1, 1'b1, 1'b0, 8'(i), 8'h00, 1'b1, 1'b0, 8'(i + 8), 8'h00, 1'b0);
    cyc("idle", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Single debug write of A5 to 0x10, then CPU reads it back
    repeat (2) cyc("dbg_write", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h10, 8'hA5, 1'b0);
    cyc("cpu_read_wait", 1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive("cpu_read", 1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    check8("cpu_read_a5", cpu_rdata, 8'hA5);
    advance();
    cyc("idle", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Halt locks the CPU out; release grants it on the next edge
    repeat (3) cyc("halt", 1'b1, 1'b1, 1'b1, 8'h03, 8'h77, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    repeat (2) cyc("unhalt", 1'b1, 1'b1, 1'b0, 8'h03, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    cyc("halt_in_cpu", 1'b1, 1'b1, 1'b0, 8'h03, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    cyc("idle", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // CPU drops its request mid-burst; the write that cycle is suppressed
    repeat (3) cyc("cpu_burst", 1'b1, 1'b1, 1'b0, 8'h04, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    cyc("cpu_drop", 1'b1, 1'b0, 1'b1, 8'h05, 8'hEE, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    cyc("after_drop", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    // Fresh burst: CPU alone, then debug joins and must wait out a full burst
    repeat (2) cyc("cpu_new", 1'b1, 1'b1, 1'b0, 8'h06, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (6) cyc("cpu_vs_dbg", 1'b1, 1'b1, 1'b0, 8'h06, 8'h00, 1'b1, 1'b0, 8'h07, 8'h00, 1'b0);

    // Randomised traffic over a small address window so reads hit earlier writes
    for (int i = 0; i < 400; i++)
      cyc("random", 1'b1,
          ($urandom_range(0, 9) < 7), $urandom_range(0, 1), 8'($urandom_range(0, 15)), 8'($urandom),
          $urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom_range(0, 15)), 8'($urandom),
          ($urandom_range(0, 9) == 0));

    // Reset falling during a debug write: the write must vanish immediately
    cyc("idle", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    cyc("dbg_burst", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h21, 8'h11, 1'b0);
    cyc("dbg_burst", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h22, 8'h22, 1'b0);
    drive("dbg_burst_last", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h20, 8'h3C, 1'b0);
    rst = 1'b0;
    model_reset();
    push_expect("reset_mid_write");
    cyc("reset_after", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h20, 8'h3C, 1'b0);
    check8("mem_0x20_kept", mem[8'h20], init_val(8'h20));
    check8("mem_0x22_written", mem[8'h22], 8'h22);
    cyc("reset_release", 1'b1, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    cyc("read_0x20", 1'b1, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    #5;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
